serial_frame_shifter: RTL

- Parallel-to-serial stage directly upstream of mearly_seq_detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clk, on dout. dout drives the detector's serial input i.
- Holding register plus shift register, so back-to-back words stream with no idle bit between them.

---
 rtl/serial_frame_shifter.sv | 96 +++++++++
 1 files changed

// File: rtl/serial_frame_shifter.sv
// serial_frame_shifter: parallel-to-serial stage, MSB-first, with a holding register for gapless streaming
module serial_frame_shifter #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             word_done_q, word_done_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             last;
    logic             load;
    logic [WIDTH-1:0] load_word;

    // ready depends only on the holding register, never on din_valid
    assign din_ready  = !hold_full_q;
    assign accept     = din_valid && din_ready;
    // LSB is on dout: the next edge either chains a new word or goes idle
    assign last       = (state_q == SHIFT) && (cnt_q == '0);
    // a held word has priority; otherwise a word accepted now goes straight to the shifter
    assign load       = ((state_q == IDLE) && accept) || (last && (hold_full_q || accept));
    assign load_word  = hold_full_q ? hold_q : din;

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign word_done  = word_done_q;
    assign busy       = busy_q;

    // state register; reset discards any word in flight
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // next state: leave SHIFT only when the last bit goes out with nothing to follow it
    always_comb begin
        state_d = (state_q == IDLE) ? (accept ? SHIFT : IDLE) : ((last && !load) ? IDLE : SHIFT);
    end

    // next values of the datapath and the registered outputs
    always_comb begin
        shift_d      = load ? load_word : ((state_q == SHIFT) ? (shift_q << 1) : shift_q);
        cnt_d        = load ? CNT_LOAD : ((cnt_q != '0) ? cnt_q - CNT_ONE : cnt_q);
        dout_d       = load ? load_word[WIDTH-1] : (((state_q == SHIFT) && !last) ? shift_q[WIDTH-2] : IDLE_LEVEL);
        dout_valid_d = load || ((state_q == SHIFT) && !last);
        word_done_d  = (state_q == SHIFT) && (cnt_q == CNT_ONE);
        hold_full_d  = last ? 1'b0 : (hold_full_q || (accept && (state_q == SHIFT)));
        hold_d       = (accept && (state_q == SHIFT) && !last) ? din : hold_q;
        busy_d       = (state_d == SHIFT) || hold_full_d;
    end

    // datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            cnt_q        <= '0;
            dout_q       <= IDLE_LEVEL;
            dout_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            word_done_q  <= word_done_d;
            busy_q       <= busy_d;
        end
    end
endmodule
